// File: rtl/mul_pkg.sv
// mul_pkg: constants and helpers shared by the iterative multiplier and by the
// decoder/stall logic that sequences it.
//   mul_state_e : 3-bit FSM encoding (IDLE=0, CALC=1, FIX_A=2, FIX_B=3, DONE=4)
//   MUL_WIDTH   : operand width (32)
//   MUL_CNT_W   : iteration counter width (6, counts 0..MUL_WIDTH)
//   add_carry_out : recovers the carry-out of a 32-bit addition from the two
//                   operand MSBs and the sum MSB (the shared adder has no cout)
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FIX_A = 3'd2,
    FIX_B = 3'd3,
    DONE  = 3'd4
  } mul_state_e;

  // A carry leaves bit 31 when both MSBs are set, or when exactly one is set
  // and the sum MSB came out clear (meaning bit 31 itself overflowed).
  function automatic logic add_carry_out(input logic x_msb,
                                         input logic y_msb,
                                         input logic s_msb);
    return (x_msb & y_msb) | ((x_msb ^ y_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/adder.sv
// adder: 32-bit ripple-carry adder, the only arithmetic element of the
// multiplier datapath. No carry-out port; callers recover it if needed.
//   a, b : 32-bit addends
//   cin  : carry into bit 0 (set to 1 together with ~b for subtraction)
//   sum  : a + b + cin, modulo 2^32
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  // carry[i] is the carry into bit i; the carry out of bit 31 is not kept.
  logic [31:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
      if (gi < 31) begin : g_carry
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative 32x32 -> 64-bit multiplier for the EX stage.
// One shift-add step per cycle through a single shared 32-bit adder, then two
// fixed correction subtractions that turn the unsigned product into the signed
// one when is_signed was set. Fixed latency: done pulses 34 edges after accept.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : request, accepted when ready=1 (IDLE or DONE)
//   is_signed  : 1 = both operands two's complement, 0 = both unsigned
//   op_a, op_b : multiplicand / multiplier, sampled on the accept edge
//   ready      : start will be accepted this cycle
//   busy       : CALC, FIX_A or FIX_B in progress
//   done       : one-cycle pulse, product valid from this cycle
//   product_hi : result bits [63:32], held until the next completion
//   product_lo : result bits [31:0], held until the next completion
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  // The shared adder is hard 32-bit; any other width cannot be built.
  generate
    if (WIDTH != 32) begin : g_width_check
      $error("seq_multiplier: WIDTH must be 32 to match adder");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_e       state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             sgn_q,    sgn_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

  // Adder port signals, steered by state.
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Correction terms: subtracting mplier<<32 when mcand is negative and
  // mcand<<32 when mplier is negative converts the unsigned product of the
  // raw bit patterns into the two's-complement product (mod 2^64).
  logic [WIDTH-1:0] k_a;
  logic [WIDTH-1:0] k_b;

  assign k_a = (sgn_q & mcand_q[WIDTH-1])  ? mplier_q : '0;
  assign k_b = (sgn_q & mplier_q[WIDTH-1]) ? mcand_q  : '0;

  always_comb begin
    add_a   = acc_hi_q;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      CALC: begin
        add_b = acc_lo_q[0] ? mcand_q : '0;
      end
      FIX_A: begin
        add_b   = ~k_a;
        add_cin = 1'b1;
      end
      FIX_B: begin
        add_b   = ~k_b;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  adder u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  // Only meaningful in CALC (cin=0); when add_b is zero this evaluates to 0.
  assign add_cout = add_carry_out(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sgn_d     = sgn_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // The multiplier lives in acc_lo and is shifted out LSB-first as
          // product bits are shifted in from acc_hi.
          mcand_d  = op_a;
          mplier_d = op_b;
          sgn_d    = is_signed;
          acc_hi_d = '0;
          acc_lo_d = op_b;
          cnt_d    = '0;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end

      CALC: begin
        // {carry, sum, acc_lo} shifted right by one.
        acc_hi_d = {add_cout, add_sum[WIDTH-1:1]};
        acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIX_A;
        end
      end

      FIX_A: begin
        acc_hi_d = add_sum;
        state_d  = FIX_B;
      end

      FIX_B: begin
        acc_hi_d  = add_sum;
        prod_hi_d = add_sum;
        prod_lo_d = acc_lo_q;
        state_d   = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sgn_q     <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sgn_q     <= sgn_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

  // All outputs decode registered state only.
  assign ready      = (state_q == IDLE) || (state_q == DONE);
  assign busy       = (state_q == CALC) || (state_q == FIX_A) || (state_q == FIX_B);
  assign done       = (state_q == DONE);
  assign product_hi = prod_hi_q;
  assign product_lo = prod_lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier. Stimulus pushes the expected
// product and accept edge into a queue; an independent monitor pops and
// compares on every done pulse, including the 34-edge latency.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  seq_multiplier dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .op_a       (op_a),
    .op_b       (op_b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done product=%h_%h required no done", product_hi, product_lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if ({product_hi, product_lo} !== e.prod) begin
          n_bad++;
          $display("FAIL %s product=%h required=%h", e.name, {product_hi, product_lo}, e.prod);
        end else begin
          $display("ok   %s product=%h", e.name, {product_hi, product_lo});
        end
        n_cmp++;
        if (cyc - e.acc_cyc != 34) begin
          n_bad++;
          $display("FAIL %s_latency edges=%0d required=34", e.name, cyc - e.acc_cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", nm, got, want);
    end else begin
      $display("ok   %s = %h", nm, got);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] expv, input string nm);
    exp_t e;
    start     = 1'b1;
    op_a      = a;
    op_b      = b;
    is_signed = s;
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept_timeout ready=%b required=1", nm, ready);
      start = 1'b0;
      return;
    end
    e.prod    = expv;
    e.acc_cyc = cyc + 1;
    e.name    = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb_;
    if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      return 64'(sa * sb_);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #12;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_done",  64'(done),  64'd0);
    check("reset_product", {product_hi, product_lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd7, 32'd6, 1'b0, 64'h00000000_0000002A, "u_7x6");
    drain();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "u_max_x_max");
    drain();
    issue(32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1, "s_m3x5");
    drain();
    issue(32'hFFFFFFFD, 32'h00000005, 1'b0, 64'h00000004_FFFFFFF1, "u_fffffffdx5");
    drain();
    issue(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "s_min_x_min");
    drain();

    // start during CALC is ignored; product holds the previous result.
    issue(32'h00001234, 32'h00000010, 1'b0, 64'h00000000_00012340, "u_busy_start");
    start = 1'b1;
    op_a  = 32'd99;
    op_b  = 32'd55;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_calc", 64'(busy), 64'd1);
    check("held_product", {product_hi, product_lo}, 64'h40000000_00000000);
    drain();

    // Async reset at iteration 10 aborts the op and clears the product.
    issue(32'h0000ABCD, 32'h00001111, 1'b0, 64'h0, "aborted");
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_busy",    64'(busy), 64'd0);
    check("abort_done",    64'(done), 64'd0);
    check("abort_ready",   64'(ready), 64'd1);
    check("abort_product", {product_hi, product_lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'd3, 32'd4, 1'b0, 64'h00000000_0000000C, "u_3x4");
    drain();

    // Back-to-back: second start accepted in the DONE cycle.
    issue(32'd7, 32'd6, 1'b0, 64'h00000000_0000002A, "b2b_7x6");
    issue(32'd12, 32'd12, 1'b0, 64'h00000000_00000090, "b2b_12x12");
    drain();

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, ref_mul(a, b, s), $sformatf("rnd%0d", i));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
